tri_pixel_buffer: RTL and testbench

Downstream stage of the triangle rasterizer. Captures the rasterizer's `po`/`xo`/`yo` pixel stream into an 8x8 bitmap and counts unique pixels. When the triangle finishes, it streams the bitmap out row by row through a valid/ready handshake, then pulses `done` with the final pixel count. It sits between the rasterizer and the display/compare logic.

---
 rtl/tri_pixel_buffer.sv | 125 ++++++++++++
 tb/tb_tri_pixel_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_pixel_buffer.sv
// tri_pixel_buffer: captures the rasterizer pixel stream into an 8x8 bitmap,
// counts unique pixels, then streams the bitmap out row by row over a
// valid/ready handshake and pulses done with the final count.
module tri_pixel_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       busy_in,
    input  logic       po,
    input  logic [2:0] xo,
    input  logic [2:0] yo,
    input  logic       row_ready,
    output logic       row_valid,
    output logic [2:0] row_idx,
    output logic [7:0] row_data,
    output logic [6:0] pix_cnt,
    output logic       done,
    output logic       overrun
);

    localparam int unsigned GRID_W  = 8;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned CNT_W   = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DUMP
    } state_t;

    state_t                         state, state_nxt;
    logic [GRID_W-1:0][GRID_W-1:0]  bm, bm_nxt;
    logic                           busy_d;
    logic                           busy_rise;
    logic [CNT_W-1:0]               cnt_nxt;
    logic                           row_valid_nxt;
    logic [COORD_W-1:0]             row_idx_nxt;
    logic [GRID_W-1:0]              row_data_nxt;
    logic                           done_nxt;
    logic                           overrun_nxt;

    assign busy_rise = busy_in & ~busy_d;

    // Next-state, bitmap update and registered-output next values
    always_comb begin
        state_nxt     = state;
        bm_nxt        = bm;
        cnt_nxt       = pix_cnt;
        row_valid_nxt = 1'b0;
        row_idx_nxt   = row_idx;
        row_data_nxt  = row_data;
        done_nxt      = 1'b0;
        overrun_nxt   = overrun | (busy_rise & (state != S_IDLE));

        case (state)
            S_IDLE: begin
                if (busy_rise) begin
                    bm_nxt    = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE, S_DRAIN: begin
                // Only a previously clear bit counts as a new pixel
                if (po && !bm[yo][xo]) begin
                    bm_nxt[yo][xo] = 1'b1;
                    cnt_nxt        = pix_cnt + CNT_W'(1);
                end
                if (state == S_CAPTURE) begin
                    if (!busy_in) begin
                        state_nxt = S_DRAIN;
                    end
                end else begin
                    // Row 0 must reflect a pixel captured in this drain cycle
                    state_nxt     = S_DUMP;
                    row_valid_nxt = 1'b1;
                    row_idx_nxt   = '0;
                    row_data_nxt  = bm_nxt[0];
                end
            end
            S_DUMP: begin
                row_valid_nxt = 1'b1;
                if (row_ready) begin
                    if (row_idx == COORD_W'(GRID_W - 1)) begin
                        row_valid_nxt = 1'b0;
                        done_nxt      = 1'b1;
                        state_nxt     = S_IDLE;
                    end else begin
                        row_idx_nxt  = row_idx + COORD_W'(1);
                        row_data_nxt = bm[row_idx + COORD_W'(1)];
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, bitmap and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bm        <= '0;
            busy_d    <= 1'b0;
            pix_cnt   <= '0;
            row_valid <= 1'b0;
            row_idx   <= '0;
            row_data  <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bm        <= bm_nxt;
            busy_d    <= busy_in;
            pix_cnt   <= cnt_nxt;
            row_valid <= row_valid_nxt;
            row_idx   <= row_idx_nxt;
            row_data  <= row_data_nxt;
            done      <= done_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_tri_pixel_buffer.sv
// tb_tri_pixel_buffer: randomized bench for tri_pixel_buffer with a set-of-pixels reference model.
module tb_tri_pixel_buffer;

    logic       clk;
    logic       reset;
    logic       busy_in;
    logic       po;
    logic [2:0] xo;
    logic [2:0] yo;
    logic       row_ready;
    logic       row_valid;
    logic [2:0] row_idx;
    logic [7:0] row_data;
    logic [6:0] pix_cnt;
    logic       done;
    logic       overrun;

    int n_cmp;
    int n_err;
    bit ref_bm [8][8];
    bit ref_overrun;

    tri_pixel_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .busy_in   (busy_in),
        .po        (po),
        .xo        (xo),
        .yo        (yo),
        .row_ready (row_ready),
        .row_valid (row_valid),
        .row_idx   (row_idx),
        .row_data  (row_data),
        .pix_cnt   (pix_cnt),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_count();
        int c = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                c += int'(ref_bm[y][x]);
        return c;
    endfunction

    function automatic logic [7:0] ref_row(input int y);
        logic [7:0] r;
        for (int x = 0; x < 8; x++) r[x] = ref_bm[y][x];
        return r;
    endfunction

    task automatic model_clear();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                ref_bm[y][x] = 1'b0;
    endtask

    // One idle cycle, then busy rises; po driven in the IDLE cycle must be ignored
    task automatic start_capture();
        busy_in = 1'b0; po = 1'b0;
        @(negedge clk);
        busy_in = 1'b1; po = 1'b1;
        xo = 3'($urandom_range(0, 7)); yo = 3'($urandom_range(0, 7));
        @(negedge clk);
        model_clear();
        n_cmp++;
        if (pix_cnt !== 7'd0) begin
            n_err++; $display("FAIL start_cnt: pix_cnt got %0d exp 0", pix_cnt);
        end
        n_cmp++;
        if (row_valid !== 1'b0) begin
            n_err++; $display("FAIL start_valid: row_valid got %b exp 0", row_valid);
        end
    endtask

    task automatic put_pixel(input logic p, input logic [2:0] x, input logic [2:0] y);
        busy_in = 1'b1; po = p; xo = x; yo = y;
        @(negedge clk);
        if (p) ref_bm[y][x] = 1'b1;
        n_cmp++;
        if (int'(pix_cnt) != ref_count()) begin
            n_err++; $display("FAIL cap_cnt: pix_cnt got %0d exp %0d", pix_cnt, ref_count());
        end
    endtask

    // busy falls; p1 lands in the last CAPTURE cycle, p2 in the DRAIN cycle
    task automatic end_capture(input logic p1, input logic [2:0] x1, input logic [2:0] y1,
                               input logic p2, input logic [2:0] x2, input logic [2:0] y2);
        busy_in = 1'b0; po = p1; xo = x1; yo = y1;
        @(negedge clk);
        if (p1) ref_bm[y1][x1] = 1'b1;
        n_cmp++;
        if (row_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_valid: row_valid got %b exp 0", row_valid);
        end
        po = p2; xo = x2; yo = y2;
        @(negedge clk);
        if (p2) ref_bm[y2][x2] = 1'b1;
        po = 1'b0;
        n_cmp++;
        if (row_valid !== 1'b1 || row_idx !== 3'd0) begin
            n_err++; $display("FAIL dump_start: valid/idx got %b/%0d exp 1/0", row_valid, row_idx);
        end
        n_cmp++;
        if (int'(pix_cnt) != ref_count()) begin
            n_err++; $display("FAIL drain_cnt: pix_cnt got %0d exp %0d", pix_cnt, ref_count());
        end
    endtask

    // Walks the dump with optional stall and busy pulse; po is randomized and must be ignored
    task automatic dump_check(input string name, input int stall_row, input int stall_len,
                              input int pulse_row, output int cycles);
        int r = 0;
        int stalled = 0;
        int cyc = 0;
        bit pulsed = 1'b0;
        bit rdy;
        while (r < 8 && cyc < 200) begin
            n_cmp++;
            if (row_valid !== 1'b1 || row_idx !== 3'(r) || row_data !== ref_row(r) || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s row%0d: valid/idx/data/done got %b/%0d/%h/%b exp 1/%0d/%h/0",
                         name, r, row_valid, row_idx, row_data, done, r, ref_row(r));
            end
            if (r == stall_row && stalled < stall_len) begin
                rdy = 1'b0; stalled++;
            end else begin
                rdy = 1'b1;
            end
            row_ready = rdy;
            busy_in = (r == pulse_row) && !pulsed;
            if (busy_in) begin
                pulsed = 1'b1; ref_overrun = 1'b1;
            end
            po = 1'($urandom_range(0, 1));
            xo = 3'($urandom_range(0, 7)); yo = 3'($urandom_range(0, 7));
            @(negedge clk);
            cyc++;
            if (rdy) r++;
        end
        busy_in = 1'b0; po = 1'b0; row_ready = 1'b0;
        n_cmp++;
        if (r < 8) begin
            n_err++; $display("FAIL %s timeout: rows accepted %0d exp 8", name, r);
        end
        n_cmp++;
        if (done !== 1'b1 || row_valid !== 1'b0) begin
            n_err++; $display("FAIL %s done: done/valid got %b/%b exp 1/0", name, done, row_valid);
        end
        n_cmp++;
        if (int'(pix_cnt) != ref_count() || overrun !== ref_overrun) begin
            n_err++; $display("FAIL %s final: cnt/overrun got %0d/%b exp %0d/%b",
                              name, pix_cnt, overrun, ref_count(), ref_overrun);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || int'(pix_cnt) != ref_count()) begin
            n_err++; $display("FAIL %s after: done/cnt got %b/%0d exp 0/%0d", name, done, pix_cnt, ref_count());
        end
        cycles = cyc;
    endtask

    task automatic capture_triangle();
        start_capture();
        for (int i = 0; i < 9; i++) begin
            case (i)
                1: put_pixel(1'b1, 3'd1, 3'd1);
                2: put_pixel(1'b1, 3'd1, 3'd2);
                3: put_pixel(1'b1, 3'd2, 3'd2);
                4: put_pixel(1'b1, 3'd3, 3'd2);
                default: put_pixel(1'b0, 3'd0, 3'd0);
            endcase
        end
        end_capture(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1; busy_in = 1'b0; po = 1'b0; xo = '0; yo = '0; row_ready = 1'b0;
        ref_overrun = 1'b0;
        model_clear();
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (row_valid !== 1'b0 || row_idx !== 3'd0 || row_data !== 8'd0 || pix_cnt !== 7'd0 ||
            done !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL reset: valid/idx/data/cnt/done/ovr got %b/%0d/%h/%0d/%b/%b exp all 0",
                              row_valid, row_idx, row_data, pix_cnt, done, overrun);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        capture_triangle();
        n_cmp++;
        if (ref_row(1) !== 8'h02 || ref_row(2) !== 8'h0E || row_data !== 8'h00) begin
            n_err++; $display("FAIL basic_rows: row0 got %h exp 00", row_data);
        end
        dump_check("basic", -1, 0, -1, cyc);
        n_cmp++;
        if (cyc != 8) begin
            n_err++; $display("FAIL basic_len: dump cycles got %0d exp 8", cyc);
        end
    endtask

    task automatic test_trailing();
        int cyc;
        start_capture();
        for (int i = 0; i < 3; i++) put_pixel(1'b0, 3'd0, 3'd0);
        end_capture(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd7);
        dump_check("trailing", -1, 0, -1, cyc);
    endtask

    task automatic test_duplicates();
        int cyc;
        start_capture();
        for (int i = 0; i < 3; i++) put_pixel(1'b1, 3'd4, 3'd5);
        end_capture(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
        dump_check("duplicates", -1, 0, -1, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        capture_triangle();
        dump_check("backpressure", 3, 5, -1, cyc);
        n_cmp++;
        if (cyc != 13) begin
            n_err++; $display("FAIL bp_len: dump cycles got %0d exp 13", cyc);
        end
    endtask

    task automatic test_overrun();
        int cyc;
        capture_triangle();
        dump_check("overrun", -1, 0, 2, cyc);
        // Sticky across a following clean run
        capture_triangle();
        dump_check("overrun_sticky", -1, 0, -1, cyc);
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        capture_triangle();
        row_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_cmp++;
        if (row_idx !== 3'd4 || row_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_row: idx/valid got %0d/%b exp 4/1", row_idx, row_valid);
        end
        reset = 1'b1;
        #1;
        ref_overrun = 1'b0;
        n_cmp++;
        if (row_valid !== 1'b0 || row_idx !== 3'd0 || row_data !== 8'd0 || pix_cnt !== 7'd0 ||
            done !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: valid/idx/data/cnt/done/ovr got %b/%0d/%h/%0d/%b/%b exp all 0",
                              row_valid, row_idx, row_data, pix_cnt, done, overrun);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || row_valid !== 1'b0) begin
                n_err++; $display("FAIL post_reset: done/valid got %b/%b exp 0/0", done, row_valid);
            end
        end
        row_ready = 1'b0;
        start_capture();
        put_pixel(1'b1, 3'd6, 3'd0);
        put_pixel(1'b1, 3'd0, 3'd7);
        end_capture(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
        dump_check("after_reset", -1, 0, -1, cyc);
    endtask

    task automatic test_full_grid();
        int cyc;
        start_capture();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                put_pixel(1'b1, 3'(x), 3'(y));
        end_capture(1'b1, 3'd3, 3'd3, 1'b1, 3'd5, 3'd6);
        n_cmp++;
        if (pix_cnt !== 7'd64) begin
            n_err++; $display("FAIL full_cnt: pix_cnt got %0d exp 64", pix_cnt);
        end
        dump_check("full_grid", -1, 0, -1, cyc);
    endtask

    task automatic test_random();
        int cyc;
        int npix;
        for (int f = 0; f < 8; f++) begin
            start_capture();
            npix = $urandom_range(0, 24);
            for (int i = 0; i < npix; i++)
                put_pixel(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end_capture(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            dump_check("random", $urandom_range(0, 7), $urandom_range(0, 4), -1, cyc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_trailing();
        test_duplicates();
        test_backpressure();
        test_overrun();
        test_reset_mid_dump();
        test_full_grid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
